// File: rtl/vga_pkg.sv
// vga_pkg: VGA timing mode constants and helpers shared by the timing generator.
package vga_pkg;
    typedef struct packed {
        int unsigned active;
        int unsigned fp;
        int unsigned sync;
        int unsigned bp;
    } vga_seg_t;
    typedef struct packed {
        vga_seg_t    h;
        vga_seg_t    v;
        logic        hs_pol;
        logic        vs_pol;
        int unsigned clk_div;
    } vga_mode_t;
    localparam vga_mode_t VGA_640X480_60 = '{
        h: '{640, 16, 96, 48}, v: '{480, 10, 2, 33},
        hs_pol: 1'b0, vs_pol: 1'b0, clk_div: 2
    };
    // 50 MHz pixel clock needs CLK_DIV=1, which the divider cannot do; kept for a future PLL-fed variant.
    localparam vga_mode_t VGA_800X600_72 = '{
        h: '{800, 56, 120, 64}, v: '{600, 37, 6, 23},
        hs_pol: 1'b1, vs_pol: 1'b1, clk_div: 1
    };
    function automatic int unsigned vga_total(input int unsigned active, input int unsigned fp,
                                              input int unsigned sync, input int unsigned bp);
        return active + fp + sync + bp;
    endfunction
endpackage

// File: rtl/vga_timing_gen_if.sv
// vga_timing_gen_if: pixel-source request/colour signals and DAC-side VGA pins.
interface vga_timing_gen_if #(
    parameter int unsigned COLOR_W = 8,
    parameter int unsigned CW      = 10
);
    logic [COLOR_W-1:0] input_red;
    logic [COLOR_W-1:0] input_green;
    logic [COLOR_W-1:0] input_blue;
    logic               pix_ce;
    logic [CW-1:0]      next_x;
    logic [CW-1:0]      next_y;
    logic               req_valid;
    logic               frame_start;
    logic               VGA_CLK;
    logic               VGA_HS;
    logic               VGA_VS;
    logic               VGA_BLANK_N;
    logic               VGA_SYNC_N;
    logic [COLOR_W-1:0] VGA_R;
    logic [COLOR_W-1:0] VGA_G;
    logic [COLOR_W-1:0] VGA_B;
    modport master (
        input  input_red, input_green, input_blue,
        output pix_ce, next_x, next_y, req_valid, frame_start,
        output VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N, VGA_R, VGA_G, VGA_B
    );
    modport slave (
        output input_red, input_green, input_blue,
        input  pix_ce, next_x, next_y, req_valid, frame_start,
        input  VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N, VGA_R, VGA_G, VGA_B
    );
endinterface

// File: rtl/vga_delay_line.sv
// vga_delay_line: clock-enabled shift register; DEPTH=0 is a straight wire.
module vga_delay_line #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_ce,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data
);
    localparam int unsigned D = (DEPTH == 0) ? 1 : DEPTH;
    logic [D-1:0][WIDTH-1:0] r_sr;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) r_sr <= '0;
        else if (i_ce) begin
            r_sr[0] <= i_data;
            for (int i = 1; i < D; i++) r_sr[i] <= r_sr[i-1];
        end
    assign o_data = (DEPTH == 0) ? i_data : r_sr[D-1];
endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA sync/blank generator issuing pixel requests LAT ticks ahead of the DAC.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE = VGA_640X480_60.h.active,
    parameter int unsigned H_FP     = VGA_640X480_60.h.fp,
    parameter int unsigned H_SYNC   = VGA_640X480_60.h.sync,
    parameter int unsigned H_BP     = VGA_640X480_60.h.bp,
    parameter int unsigned V_ACTIVE = VGA_640X480_60.v.active,
    parameter int unsigned V_FP     = VGA_640X480_60.v.fp,
    parameter int unsigned V_SYNC   = VGA_640X480_60.v.sync,
    parameter int unsigned V_BP     = VGA_640X480_60.v.bp,
    parameter bit          HS_POL   = 1'b0,
    parameter bit          VS_POL   = 1'b0,
    parameter int unsigned CLK_DIV  = 2,
    parameter int unsigned LAT      = 2,
    parameter int unsigned COLOR_W  = 8,
    parameter int unsigned CW       = 10
) (
    input  logic             CLOCK_50,
    input  logic             reset_n,
    vga_timing_gen_if.master vga
);
    localparam int unsigned   H_TOTAL  = vga_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int unsigned   V_TOTAL  = vga_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int unsigned   DW       = $clog2(CLK_DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV / 2);
    localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_ACT    = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_ACT    = CW'(V_ACTIVE);
    localparam logic [CW-1:0] HS_BEG   = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] HS_END   = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] VS_BEG   = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] VS_END   = CW'(V_ACTIVE + V_FP + V_SYNC);
    logic [DW-1:0]      r_div;
    logic [CW-1:0]      r_hc;
    logic [CW-1:0]      r_vc;
    logic               r_run;
    logic               r_hs;
    logic               r_vs;
    logic               r_blank_n;
    logic [COLOR_W-1:0] r_red;
    logic [COLOR_W-1:0] r_green;
    logic [COLOR_W-1:0] r_blue;
    logic               w_ce;
    logic               w_req;
    logic               w_hs;
    logic               w_vs;
    logic [2:0]         w_dly;
    always_ff @(posedge CLOCK_50 or negedge reset_n)
        if (!reset_n) begin
            r_div <= '0;
            r_hc  <= '0;
            r_vc  <= '0;
            r_run <= 1'b0;
        end else begin
            r_run <= 1'b1;
            r_div <= w_ce ? '0 : r_div + 1'b1;
            if (w_ce) begin
                r_hc <= (r_hc == H_LAST) ? '0 : r_hc + 1'b1;
                if (r_hc == H_LAST) r_vc <= (r_vc == V_LAST) ? '0 : r_vc + 1'b1;
            end
        end
    // r_run keeps req_valid low while the counters sit at their (0,0) reset value
    always_comb begin
        w_ce  = (r_div == DIV_LAST);
        w_req = r_run && (r_hc < H_ACT) && (r_vc < V_ACT);
        w_hs  = (r_hc >= HS_BEG) && (r_hc < HS_END);
        w_vs  = (r_vc >= VS_BEG) && (r_vc < VS_END);
    end
    vga_delay_line #(.WIDTH(3), .DEPTH(LAT)) u_dly (
        .clk    (CLOCK_50),
        .rst_n  (reset_n),
        .i_ce   (w_ce),
        .i_data ({w_hs, w_vs, w_req}),
        .o_data (w_dly)
    );
    // sync bits are stored as "active" so a cleared pipeline means inactive for either polarity
    always_ff @(posedge CLOCK_50 or negedge reset_n)
        if (!reset_n) begin
            r_hs      <= 1'b0;
            r_vs      <= 1'b0;
            r_blank_n <= 1'b0;
            r_red     <= '0;
            r_green   <= '0;
            r_blue    <= '0;
        end else if (w_ce) begin
            {r_hs, r_vs, r_blank_n} <= w_dly;
            r_red   <= w_dly[0] ? vga.input_red   : '0;
            r_green <= w_dly[0] ? vga.input_green : '0;
            r_blue  <= w_dly[0] ? vga.input_blue  : '0;
        end
    assign vga.pix_ce      = w_ce;
    assign vga.next_x      = w_req ? r_hc : '0;
    assign vga.next_y      = w_req ? r_vc : '0;
    assign vga.req_valid   = w_req;
    assign vga.frame_start = w_ce && (r_hc == '0) && (r_vc == '0);
    assign vga.VGA_CLK     = (r_div >= DIV_HALF);
    assign vga.VGA_HS      = r_hs ? HS_POL : ~HS_POL;
    assign vga.VGA_VS      = r_vs ? VS_POL : ~VS_POL;
    assign vga.VGA_BLANK_N = r_blank_n;
    assign vga.VGA_SYNC_N  = 1'b0;
    assign vga.VGA_R       = r_red;
    assign vga.VGA_G       = r_green;
    assign vga.VGA_B       = r_blue;
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed checks of default, swept-parameter and latency-aligned VGA timing instances.
module tb_vga_timing_gen;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rn0 = 1'b0;
    logic rn1 = 1'b0;
    logic rn2 = 1'b0;
    int   checks = 0;
    int   errors = 0;
    vga_timing_gen_if #(.COLOR_W(8), .CW(10)) if0 ();
    vga_timing_gen_if #(.COLOR_W(8), .CW(10)) if1 ();
    vga_timing_gen_if #(.COLOR_W(8), .CW(10)) if2 ();
    vga_timing_gen u0 (.CLOCK_50(clk), .reset_n(rn0), .vga(if0));
    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b1), .VS_POL(1'b1), .CLK_DIV(3), .LAT(0)
    ) u1 (.CLOCK_50(clk), .reset_n(rn1), .vga(if1));
    vga_timing_gen #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(2),
        .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1)
    ) u2 (.CLOCK_50(clk), .reset_n(rn2), .vga(if2));
    // two-tick pixel RAM: colour = {x[7:0], y[7:0], x^y}
    logic [23:0] ram1 = '0;
    logic [23:0] ram2 = '0;
    always @(posedge clk)
        if (if2.pix_ce) begin
            ram1 <= {if2.next_x[7:0], if2.next_y[7:0], if2.next_x[7:0] ^ if2.next_y[7:0]};
            ram2 <= ram1;
        end
    assign {if2.input_red, if2.input_green, if2.input_blue} = ram2;
    function automatic logic ce_of(input int w);
        return (w == 0) ? if0.pix_ce : (w == 1) ? if1.pix_ce : if2.pix_ce;
    endfunction
    function automatic logic fs_of(input int w);
        return (w == 0) ? if0.frame_start : (w == 1) ? if1.frame_start : if2.frame_start;
    endfunction
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic adv(input int w, input int n);
        for (int i = 0; i < n; i++) begin
            int g = 0;
            while (!ce_of(w) && g < 16) begin
                @(negedge clk);
                g++;
            end
            if (g == 16) begin
                chk("pix_ce_stall", 32'(ce_of(w)), 32'd1);
                return;
            end
            @(negedge clk);
        end
    endtask
    task automatic wait_fs(input int w, input int limit, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(ce_of(w) && fs_of(w)) && n < limit);
    endtask
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation timeout");
        $fatal(1, "timeout");
    end
    initial begin
        int n;
        int bad;
        int vis;
        int vsl;
        int hsl;
        {if0.input_red, if0.input_green, if0.input_blue} = 24'h3C5A66;
        {if1.input_red, if1.input_green, if1.input_blue} = 24'hA59669;
        repeat (10) @(negedge clk);
        chk("u0_rst_vga_clk", 32'(if0.VGA_CLK), 32'd0);
        chk("u0_rst_pix_ce", 32'(if0.pix_ce), 32'd0);
        chk("u0_rst_req_valid", 32'(if0.req_valid), 32'd0);
        chk("u0_rst_frame_start", 32'(if0.frame_start), 32'd0);
        chk("u0_rst_next_x", 32'(if0.next_x), 32'd0);
        chk("u0_rst_next_y", 32'(if0.next_y), 32'd0);
        chk("u0_rst_blank_n", 32'(if0.VGA_BLANK_N), 32'd0);
        chk("u0_rst_rgb", 32'({if0.VGA_R, if0.VGA_G, if0.VGA_B}), 32'd0);
        chk("u0_rst_hs", 32'(if0.VGA_HS), 32'd1);
        chk("u0_rst_vs", 32'(if0.VGA_VS), 32'd1);
        chk("u0_sync_n", 32'(if0.VGA_SYNC_N), 32'd0);
        chk("u1_rst_hs", 32'(if1.VGA_HS), 32'd0);
        chk("u1_rst_vs", 32'(if1.VGA_VS), 32'd0);
        chk("u2_rst_hs", 32'(if2.VGA_HS), 32'd1);
        // default 640x480 instance: line timing
        rn0 = 1'b1;
        chk("u0_ce_before_edge1", 32'(if0.pix_ce), 32'd0);
        @(negedge clk);
        chk("u0_first_ce", 32'(if0.pix_ce), 32'd1);
        chk("u0_first_fs", 32'(if0.frame_start), 32'd1);
        chk("u0_first_x", 32'(if0.next_x), 32'd0);
        chk("u0_first_y", 32'(if0.next_y), 32'd0);
        chk("u0_first_valid", 32'(if0.req_valid), 32'd1);
        chk("u0_first_vga_clk", 32'(if0.VGA_CLK), 32'd1);
        adv(0, 3);
        chk("u0_px0_blank_n", 32'(if0.VGA_BLANK_N), 32'd1);
        chk("u0_px0_rgb", 32'({if0.VGA_R, if0.VGA_G, if0.VGA_B}), 32'h3C5A66);
        chk("u0_px0_hs", 32'(if0.VGA_HS), 32'd1);
        chk("u0_req_x3", 32'(if0.next_x), 32'd3);
        adv(0, 637);
        chk("u0_req640_valid", 32'(if0.req_valid), 32'd0);
        chk("u0_req640_x", 32'(if0.next_x), 32'd0);
        adv(0, 2);
        chk("u0_px639_blank_n", 32'(if0.VGA_BLANK_N), 32'd1);
        adv(0, 1);
        chk("u0_px640_blank_n", 32'(if0.VGA_BLANK_N), 32'd0);
        chk("u0_px640_rgb", 32'({if0.VGA_R, if0.VGA_G, if0.VGA_B}), 32'd0);
        adv(0, 15);
        chk("u0_px655_hs", 32'(if0.VGA_HS), 32'd1);
        adv(0, 1);
        chk("u0_px656_hs", 32'(if0.VGA_HS), 32'd0);
        adv(0, 95);
        chk("u0_px751_hs", 32'(if0.VGA_HS), 32'd0);
        adv(0, 1);
        chk("u0_px752_hs", 32'(if0.VGA_HS), 32'd1);
        adv(0, 45);
        chk("u0_line1_x", 32'(if0.next_x), 32'd0);
        chk("u0_line1_y", 32'(if0.next_y), 32'd1);
        chk("u0_line1_valid", 32'(if0.req_valid), 32'd1);
        adv(0, 658);
        chk("u0_l1_px655_hs", 32'(if0.VGA_HS), 32'd1);
        adv(0, 1);
        chk("u0_l1_px656_hs", 32'(if0.VGA_HS), 32'd0);
        chk("u0_l1_vs", 32'(if0.VGA_VS), 32'd1);
        // swept instance: 12-tick lines, 7-line frames, active-high sync, divide-by-3
        rn1 = 1'b1;
        chk("u1_div0_clk", 32'(if1.VGA_CLK), 32'd0);
        chk("u1_div0_ce", 32'(if1.pix_ce), 32'd0);
        @(negedge clk);
        chk("u1_div1_clk", 32'(if1.VGA_CLK), 32'd1);
        chk("u1_div1_ce", 32'(if1.pix_ce), 32'd0);
        @(negedge clk);
        chk("u1_div2_clk", 32'(if1.VGA_CLK), 32'd1);
        chk("u1_div2_ce", 32'(if1.pix_ce), 32'd1);
        chk("u1_first_fs", 32'(if1.frame_start), 32'd1);
        adv(1, 1);
        chk("u1_px0_blank_n", 32'(if1.VGA_BLANK_N), 32'd1);
        chk("u1_px0_r", 32'(if1.VGA_R), 32'hA5);
        chk("u1_px0_hs", 32'(if1.VGA_HS), 32'd0);
        chk("u1_px0_vs", 32'(if1.VGA_VS), 32'd0);
        adv(1, 9);
        chk("u1_px9_hs", 32'(if1.VGA_HS), 32'd1);
        chk("u1_px9_blank_n", 32'(if1.VGA_BLANK_N), 32'd0);
        chk("u1_px9_r", 32'(if1.VGA_R), 32'd0);
        adv(1, 1);
        chk("u1_px10_hs", 32'(if1.VGA_HS), 32'd1);
        adv(1, 1);
        chk("u1_px11_hs", 32'(if1.VGA_HS), 32'd0);
        chk("u1_req_y1", 32'(if1.next_y), 32'd1);
        chk("u1_req_x0", 32'(if1.next_x), 32'd0);
        adv(1, 9);
        chk("u1_l1_px8_hs", 32'(if1.VGA_HS), 32'd0);
        adv(1, 1);
        chk("u1_l1_px9_hs", 32'(if1.VGA_HS), 32'd1);
        adv(1, 38);
        chk("u1_l4_vs", 32'(if1.VGA_VS), 32'd0);
        adv(1, 1);
        chk("u1_l5_first_vs", 32'(if1.VGA_VS), 32'd1);
        adv(1, 11);
        chk("u1_l5_last_vs", 32'(if1.VGA_VS), 32'd1);
        adv(1, 1);
        chk("u1_l6_vs", 32'(if1.VGA_VS), 32'd0);
        wait_fs(1, 400, n);
        chk("u1_fs_found", 32'(if1.frame_start), 32'd1);
        wait_fs(1, 400, n);
        chk("u1_frame_cycles", 32'(n), 32'd252);
        // latency-aligned instance with the two-tick RAM model
        rn2 = 1'b1;
        wait_fs(2, 10, n);
        chk("u2_fs_after_release", 32'(n), 32'd1);
        chk("u2_fs_x", 32'(if2.next_x), 32'd0);
        adv(2, 3);
        chk("u2_px00_blank_n", 32'(if2.VGA_BLANK_N), 32'd1);
        chk("u2_px00_rgb", 32'({if2.VGA_R, if2.VGA_G, if2.VGA_B}), 32'h000000);
        adv(2, 1);
        chk("u2_px10_rgb", 32'({if2.VGA_R, if2.VGA_G, if2.VGA_B}), 32'h010001);
        adv(2, 134);
        chk("u2_px15_5_blank_n", 32'(if2.VGA_BLANK_N), 32'd1);
        chk("u2_px15_5_rgb", 32'({if2.VGA_R, if2.VGA_G, if2.VGA_B}), 32'h0F050A);
        adv(2, 1);
        chk("u2_px16_5_blank_n", 32'(if2.VGA_BLANK_N), 32'd0);
        chk("u2_px16_5_rgb", 32'({if2.VGA_R, if2.VGA_G, if2.VGA_B}), 32'd0);
        bad = 0;
        vis = 0;
        vsl = 0;
        hsl = 0;
        for (int i = 0; i < 240; i++) begin
            adv(2, 1);
            if (!if2.VGA_BLANK_N && {if2.VGA_R, if2.VGA_G, if2.VGA_B} != 24'd0) bad++;
            if (if2.VGA_BLANK_N) vis++;
            if (!if2.VGA_VS) vsl++;
            if (!if2.VGA_HS) hsl++;
        end
        chk("u2_rgb_in_blank", 32'(bad), 32'd0);
        chk("u2_visible_per_frame", 32'(vis), 32'd96);
        chk("u2_vs_ticks", 32'(vsl), 32'd48);
        chk("u2_hs_ticks", 32'(hsl), 32'd40);
        wait_fs(2, 1000, n);
        wait_fs(2, 1000, n);
        chk("u2_frame_cycles", 32'(n), 32'd480);
        adv(2, 85);
        chk("u2_px10_3_rgb", 32'({if2.VGA_R, if2.VGA_G, if2.VGA_B}), 32'h0A0309);
        chk("u2_px10_3_blank_n", 32'(if2.VGA_BLANK_N), 32'd1);
        chk("u2_req_x13", 32'(if2.next_x), 32'd13);
        chk("u2_req_y3", 32'(if2.next_y), 32'd3);
        #2 rn2 = 1'b0;
        #1;
        chk("u2_mid_rst_blank_n", 32'(if2.VGA_BLANK_N), 32'd0);
        chk("u2_mid_rst_rgb", 32'({if2.VGA_R, if2.VGA_G, if2.VGA_B}), 32'd0);
        chk("u2_mid_rst_hs", 32'(if2.VGA_HS), 32'd1);
        chk("u2_mid_rst_vs", 32'(if2.VGA_VS), 32'd1);
        chk("u2_mid_rst_vga_clk", 32'(if2.VGA_CLK), 32'd0);
        chk("u2_mid_rst_ce", 32'(if2.pix_ce), 32'd0);
        chk("u2_mid_rst_xy", 32'({if2.next_x, if2.next_y}), 32'd0);
        chk("u2_mid_rst_valid", 32'(if2.req_valid), 32'd0);
        @(negedge clk);
        rn2 = 1'b1;
        wait_fs(2, 10, n);
        chk("u2_restart_fs", 32'(n), 32'd1);
        chk("u2_restart_xy", 32'({if2.next_x, if2.next_y}), 32'd0);
        chk("u2_restart_valid", 32'(if2.req_valid), 32'd1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
